chroma_upsample_csc_pipe: RTL
=============================

Name: chroma_upsample_csc_pipe

Overview:
- Streaming successor to the Milestone-1 upsample/colour-convert datapath.
- Accepts YUV 4:2:2 pixel pairs on a valid/ready input: one Y pair plus one even-position U and one even-position V sample per pair.
- Interpolates odd-position chroma, converts both pixels to RGB and emits packed RGB pairs on a valid/ready output.
- Line length, frame height and interpolation mode are generalised. Sits between the SRAM fetch sequencer and the RGB write-back sequencer.

Parameters:
- LINE_PAIRS, 160, pixel pairs per line; legal range is 4 or more.
- LINES, 240, lines per frame.
- CW, 32, signed internal width for the FIR and CSC accumulators.

Ports:
- CLOCK_50_I  in  1  clock
- resetn  in  1  reset: resetn, asynchronous, active-low; clock CLOCK_50_I
- interp_mode  in  1  0 = 6-tap FIR interpolation, 1 = replicate even chroma; sampled at the first accepted pair of each line
- in_valid  in  1  input pair valid
- in_ready  out  1  input pair accepted when in_valid & in_ready
- in_y  in  16  {Y_even[15:8], Y_odd[7:0]}, unsigned
- in_u  in  8  even U sample, unsigned
- in_v  in  8  even V sample, unsigned
- out_valid  out  1  output pair valid
- out_ready  in  1  downstream accepts when out_valid & out_ready
- out_rgb  out  48  {R0,G0,B0,R1,G1,B1}
- line_done  out  1  1-cycle pulse when the last pair of a line is accepted downstream
- frame_done  out  1  1-cycle pulse, coincident with line_done, for the last line of the frame

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_rgb=0, line_done=0, frame_done=0.
- Reset clears all windows, counters, win_valid and state. Reset mid-line discards all in-flight data; the next accepted pair is treated as index 0 of line 0.
- State machine: IDLE -> RUN immediately after reset (first cycle); RUN -> DRAIN after accepting input index LINE_PAIRS-1; DRAIN -> RUN after 3 drain shifts complete; line/frame counters wrap to 0 after LINES lines.
- Window: two 6-entry byte shift registers (U and V) w0..w5 = chroma[j-2..j+3] for output index j. A 4-deep Y-pair delay line is aligned to w2.
- Input index 0: load w0=w1=w2=w3=w4=w5=in_u (left clamp; same for V). Indices 1..3 shift in. Accepting index k≥3 shifts in and sets win_valid, covering output j=k-3.
- DRAIN: 3 shifts with no input; each shifts in a copy of w5 (right clamp), sets win_valid and produces outputs LINE_PAIRS-3..LINE_PAIRS-1. A drain shift occurs only when the window can advance; in_ready=0 in DRAIN.
- Advance/load rules:
  - load_out = win_valid & (~out_valid | out_ready). On load_out, out_rgb is loaded and out_valid is set; win_valid clears unless the window advances in the same cycle.
  - in_ready = (state==RUN) & (~win_valid | load_out). This gives 1 pair/clock throughput with no backpressure.
  - out_valid clears on out_ready when there is no new load_out.
- Latency: input k (k≥3) accepted at edge t -> out_valid with output j=k-3 at edge t+1. The last line output appears 3 drain cycles after the last input.
- Backpressure: out_ready=0 holds out_rgb/out_valid stable and stalls the window and drain. No data is lost or duplicated.
- FIR (mode 0):
  - acc = 21(w0+w5) - 52(w1+w4) + 159(w2+w3) + 128, signed CW.
  - odd = acc >>> 8, clamped to 0..255.
- Mode 1: odd = w2.
- Mode is held for the whole line, including drain.
- CSC, per pixel (Y, U, V), with y=Y-16, u=U-128, v=V-128:
  - R = 76284y + 104595v
  - G = 76284y - 25624u - 53281v
  - B = 76284y + 132251u
  - Each result is >>> 16 then clamped to 0..255.
  - Pixel 0 uses (Y_even, w2U, w2V); pixel 1 uses (Y_odd, oddU, oddV).
- line_done/frame_done pulse on the handshake of output LINE_PAIRS-1 (frame_done also requires line==LINES-1).

Test Plan:
- Constant Y=16, U=V=128, 160 pairs, out_ready=1 -> 160 outputs, all 48'h0; line_done once, 4 cycles after the last input.
- Y pair {235,255}, U=V=128 -> R0=G0=B0=8'd254, R1=G1=B1=8'd255 (clamp).
- LINE_PAIRS=8, mode 0, U=0,8,...,56, V=128 -> oddU: j=0 gives 4, j=7 gives 56 (edge clamps); constant-chroma lines give oddU equal to the input.
- Same line in mode 1 -> oddU equals the even U of the same pair; mode toggled mid-line has no effect until the next line.
- Random out_ready (50%) over 2 lines -> output sequence identical to the out_ready=1 run; out_rgb is stable while stalled; in_ready=0 throughout DRAIN.
- resetn pulsed after 5 pairs of line 1 -> all outputs 0 at once; the next line is processed as line 0; LINES=2 frame gives frame_done exactly once on the final pair.

Source files
------------

// File: rtl/chroma_upsample_csc_pipe.sv
// chroma_upsample_csc_pipe: streaming YUV 4:2:2 -> RGB pair pipeline.
// Odd-position chroma is rebuilt from a 6-sample window (6-tap FIR or
// even-sample replication), then both pixels of a pair go through the CSC.
//
// state | meaning
// IDLE  | first cycle out of reset, no traffic
// RUN   | accepting input pairs of the current line
// DRAIN | no input; three right-clamped shifts flush the line tail
module chroma_upsample_csc_pipe #(
  parameter int LINE_PAIRS = 160,
  parameter int LINES      = 240,
  parameter int CW         = 32
) (
  input  logic        CLOCK_50_I,
  input  logic        resetn,
  input  logic        interp_mode,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_y,
  input  logic [7:0]  in_u,
  input  logic [7:0]  in_v,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [47:0] out_rgb,
  output logic        line_done,
  output logic        frame_done
);

  localparam int IW = $clog2(LINE_PAIRS);
  localparam int LW = (LINES > 1) ? $clog2(LINES) : 1;

  localparam logic signed [CW-1:0] K_Y   = CW'(76284);
  localparam logic signed [CW-1:0] K_RV  = CW'(104595);
  localparam logic signed [CW-1:0] K_GU  = CW'(25624);
  localparam logic signed [CW-1:0] K_GV  = CW'(53281);
  localparam logic signed [CW-1:0] K_BU  = CW'(132251);
  localparam logic signed [CW-1:0] K_F0  = CW'(21);
  localparam logic signed [CW-1:0] K_F1  = CW'(52);
  localparam logic signed [CW-1:0] K_F2  = CW'(159);
  localparam logic signed [CW-1:0] K_RND = CW'(128);
  localparam logic signed [CW-1:0] K_16  = CW'(16);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t          state_q;
  logic [IW-1:0]   in_idx_q;
  logic [IW-1:0]   out_idx_q;
  logic [LW-1:0]   out_line_q;
  logic [1:0]      drain_cnt_q;
  logic [7:0]      wu_q [6];
  logic [7:0]      wv_q [6];
  logic [15:0]     yd_q [4];
  logic            win_valid_q;
  logic            mode_q;
  logic            out_valid_q;
  logic [47:0]     out_rgb_q;

  logic            load_out;
  logic            accept;
  logic            drain_shift;
  logic            out_hs;
  logic [7:0]      odd_u;
  logic [7:0]      odd_v;
  logic [47:0]     rgb_d;

  function automatic logic signed [CW-1:0] sx(input logic [7:0] b);
    return $signed({{(CW-8){1'b0}}, b});
  endfunction

  function automatic logic [7:0] clip8(input logic signed [CW-1:0] a);
    if (a < 0) return 8'd0;
    else if (a > 255) return 8'd255;
    else return a[7:0];
  endfunction

  function automatic logic [7:0] fir(input logic [7:0] a0, input logic [7:0] a1,
                                     input logic [7:0] a2, input logic [7:0] a3,
                                     input logic [7:0] a4, input logic [7:0] a5);
    logic signed [CW-1:0] acc;
    acc = K_F0 * (sx(a0) + sx(a5)) - K_F1 * (sx(a1) + sx(a4))
        + K_F2 * (sx(a2) + sx(a3)) + K_RND;
    return clip8(acc >>> 8);
  endfunction

  function automatic logic [23:0] csc(input logic [7:0] y8, input logic [7:0] u8,
                                      input logic [7:0] v8);
    logic signed [CW-1:0] y, u, v, r, g, b;
    y = sx(y8) - K_16;
    u = sx(u8) - K_RND;
    v = sx(v8) - K_RND;
    r = K_Y * y + K_RV * v;
    g = K_Y * y - K_GU * u - K_GV * v;
    b = K_Y * y + K_BU * u;
    return {clip8(r >>> 16), clip8(g >>> 16), clip8(b >>> 16)};
  endfunction

  // Handshake and window-advance qualifiers.
  always_comb begin
    load_out    = win_valid_q & (~out_valid_q | out_ready);
    in_ready    = (state_q == S_RUN) & (~win_valid_q | load_out);
    accept      = in_valid & in_ready;
    drain_shift = (state_q == S_DRAIN) & (~win_valid_q | load_out);
    out_hs      = out_valid_q & out_ready;
    line_done   = out_hs & (out_idx_q == IW'(LINE_PAIRS - 1));
    frame_done  = line_done & (out_line_q == LW'(LINES - 1));
  end

  // Odd chroma reconstruction and colour conversion of the window centre.
  always_comb begin
    odd_u = mode_q ? wu_q[2] : fir(wu_q[0], wu_q[1], wu_q[2], wu_q[3], wu_q[4], wu_q[5]);
    odd_v = mode_q ? wv_q[2] : fir(wv_q[0], wv_q[1], wv_q[2], wv_q[3], wv_q[4], wv_q[5]);
    rgb_d = {csc(yd_q[0][15:8], wu_q[2], wv_q[2]), csc(yd_q[0][7:0], odd_u, odd_v)};
  end

  // Sequencer, window/delay line and output register.
  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      in_idx_q    <= '0;
      out_idx_q   <= '0;
      out_line_q  <= '0;
      drain_cnt_q <= '0;
      win_valid_q <= 1'b0;
      mode_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_rgb_q   <= '0;
      for (int i = 0; i < 6; i++) begin
        wu_q[i] <= '0;
        wv_q[i] <= '0;
      end
      for (int i = 0; i < 4; i++) yd_q[i] <= '0;
    end else begin
      if (load_out) begin
        out_rgb_q   <= rgb_d;
        out_valid_q <= 1'b1;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end

      if (out_hs) begin
        if (out_idx_q == IW'(LINE_PAIRS - 1)) begin
          out_idx_q  <= '0;
          out_line_q <= (out_line_q == LW'(LINES - 1)) ? '0 : out_line_q + LW'(1);
        end else begin
          out_idx_q <= out_idx_q + IW'(1);
        end
      end

      if ((accept && in_idx_q >= IW'(3)) || drain_shift) win_valid_q <= 1'b1;
      else if (load_out) win_valid_q <= 1'b0;

      case (state_q)
        S_IDLE: state_q <= S_RUN;
        S_RUN: begin
          if (accept) begin
            if (in_idx_q == '0) begin
              // Left edge: the whole window starts as copies of sample 0.
              for (int i = 0; i < 6; i++) begin
                wu_q[i] <= in_u;
                wv_q[i] <= in_v;
              end
              mode_q <= interp_mode;
            end else begin
              for (int i = 0; i < 5; i++) begin
                wu_q[i] <= wu_q[i+1];
                wv_q[i] <= wv_q[i+1];
              end
              wu_q[5] <= in_u;
              wv_q[5] <= in_v;
            end
            for (int i = 0; i < 3; i++) yd_q[i] <= yd_q[i+1];
            yd_q[3] <= in_y;
            if (in_idx_q == IW'(LINE_PAIRS - 1)) begin
              in_idx_q <= '0;
              state_q  <= S_DRAIN;
            end else begin
              in_idx_q <= in_idx_q + IW'(1);
            end
          end
        end
        S_DRAIN: begin
          if (drain_shift) begin
            // Right edge: replicate the last sample into the window.
            for (int i = 0; i < 5; i++) begin
              wu_q[i] <= wu_q[i+1];
              wv_q[i] <= wv_q[i+1];
            end
            for (int i = 0; i < 3; i++) yd_q[i] <= yd_q[i+1];
            yd_q[3] <= 16'h0;
            if (drain_cnt_q == 2'd2) begin
              drain_cnt_q <= '0;
              state_q     <= S_RUN;
            end else begin
              drain_cnt_q <= drain_cnt_q + 2'd1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_rgb   = out_rgb_q;

endmodule
